// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: turns a synchronous FIFO read port (rd_en/empty, 1-cycle data latency) into a
// valid/ready stream through a 2-entry output buffer. Define FIFO_RD_CNT_EN to add the rd_cnt transfer counter.
module fifo_rd_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]      rd_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e       state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             m_valid_q, m_valid_d;

  logic             pop;
  logic             capture;
  logic [2:0]       level;

  // Read strobe: only issue a read if the word is guaranteed a buffer slot when it lands.
  always_comb begin
    pop        = m_valid_q & m_ready;
    capture    = inflight_q;
    level      = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = ~rst & ~fifo_empty & (level < 3'd2);
  end

  // Buffer next state: head is always the oldest word, tail the second one.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_rd_en;
    case (state_q)
      ST_EMPTY: begin
        if (capture) begin
          state_d = ST_ONE;
          head_d  = fifo_dout;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (capture && pop) begin
          state_d = ST_ONE;
          head_d  = fifo_dout;
        end else if (capture) begin
          state_d = ST_TWO;
          tail_d  = fifo_dout;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        // A capture without pop cannot occur here because reads are throttled at occ+inflight=2.
        if (pop && capture) begin
          state_d = ST_TWO;
          head_d  = tail_q;
          tail_d  = fifo_dout;
        end else if (pop) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    m_valid_d = (state_d != ST_EMPTY);
  end

  // Buffer state, in-flight flag and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data  = head_q;
  assign m_valid = m_valid_q;

`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // Transfer counter, wraps naturally at 16 bits.
  always_comb begin
    if (pop) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
`endif

endmodule
